// File: rtl/karatsuba_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : karatsuba_pkg                                                |
// | Description : Shared defaults, FSM state encoding and per-product cycle    |
// |               count for the Karatsuba GF(2)[x] multiplier scheduler.       |
// | Ports       : none (package)                                               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package karatsuba_pkg;

    // Operand width and half width used when the top is not overridden.
    localparam int c_W_DEFAULT  = 224;
    localparam int c_H_DEFAULT  = c_W_DEFAULT / 2;

    // Each partial product consumes one multiplier bit per cycle.
    localparam int c_MUL_CYCLES = c_H_DEFAULT;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_HI  = 3'd1,
        MUL_LO  = 3'd2,
        MUL_MID = 3'd3,
        COMBINE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/karatsuba_gf2_scheduler_clmul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clmul_serial                                                 |
// | Description : H-by-H bit-serial carry-less multiplier, MSB first.          |
// |               load captures x/y and already folds in the top bit of y, so  |
// |               a product needs the load cycle plus H-1 step cycles.         |
// | Ports       : clk, rst        clock, synchronous active-high reset         |
// |               load            start a new product from x, y               |
// |               step            consume the next multiplier bit             |
// |               x [H-1:0]       multiplicand                                |
// |               y [H-1:0]       multiplier                                  |
// |               p [2H-1:0]      running / final product                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module clmul_serial
    import karatsuba_pkg::*;
#(
    parameter int H = c_H_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [H-1:0]   x,
    input  logic [H-1:0]   y,
    output logic [2*H-1:0] p
);

    logic [H-1:0]   r_x;
    logic [H-1:0]   r_y;
    logic [2*H-1:0] r_p;

    // Horner form: shift the partial result up one degree, then XOR in x
    // when the current multiplier bit is set. Degree never exceeds 2H-2,
    // so the left shift cannot drop a set bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
            r_p <= '0;
        end else if (load) begin
            r_x <= x;
            r_y <= y << 1;
            r_p <= y[H-1] ? {{H{1'b0}}, x} : '0;
        end else if (step) begin
            r_y <= r_y << 1;
            r_p <= (r_p << 1) ^ (r_y[H-1] ? {{H{1'b0}}, r_x} : '0);
        end
    end

    assign p = r_p;

endmodule
`default_nettype wire

// File: rtl/karatsuba_gf2_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : karatsuba_gf2_scheduler                                      |
// | Description : One-level Karatsuba multiplier over GF(2)[x]. Three half-    |
// |               width partial products are computed in turn on a single      |
// |               serial carry-less multiplier and then XOR-combined.          |
// | Ports       : clk, rst        clock, synchronous active-high reset         |
// |               start           request, sampled only while busy=0           |
// |               a, b [W-1:0]    operands, bit i = coefficient of x^i         |
// |               busy            operation in progress                        |
// |               done            one-cycle completion pulse                   |
// |               c [2W-1:0]      product, held until the next done            |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module karatsuba_gf2_scheduler
    import karatsuba_pkg::*;
#(
    parameter int W = c_W_DEFAULT,   // must be even
    parameter int H = W / 2          // always derived from W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] c
);

    // One-hot cycle counter: bit k set means k+1 multiplier bits consumed,
    // so the top bit marks the last cycle of a product without any adder.
    localparam logic [H-1:0] c_CNT_FIRST = {{(H-1){1'b0}}, 1'b1};

    state_t         r_state;
    state_t         w_next;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [H-1:0]   r_cnt;
    logic [2*H-1:0] r_phi;
    logic [2*H-1:0] r_plo;
    logic [2*W-1:0] r_c;
    logic           r_done;

    logic           w_last;
    logic           w_load;
    logic           w_step;
    logic [H-1:0]   w_x;
    logic [H-1:0]   w_y;
    logic [2*H-1:0] w_p;
    logic [2*H-1:0] w_mid;
    logic [2*W-1:0] w_comb;

    assign w_last = r_cnt[H-1];

    clmul_serial #(
        .H (H)
    ) u_clmul (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .step (w_step),
        .x    (w_x),
        .y    (w_y),
        .p    (w_p)
    );

    // Next state and operand-select mux. The next product is loaded on the
    // same edge that leaves the previous state, so there is no gap cycle.
    // The high halves are taken straight from the ports on start because the
    // operand registers are only written on that same edge.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_x    = '0;
        w_y    = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = MUL_HI;
                    w_load = 1'b1;
                    w_x    = a[W-1:H];
                    w_y    = b[W-1:H];
                end
            end
            MUL_HI: begin
                if (w_last) begin
                    w_next = MUL_LO;
                    w_load = 1'b1;
                    w_x    = r_a[H-1:0];
                    w_y    = r_b[H-1:0];
                end else begin
                    w_step = 1'b1;
                end
            end
            MUL_LO: begin
                if (w_last) begin
                    w_next = MUL_MID;
                    w_load = 1'b1;
                    w_x    = r_a[W-1:H] ^ r_a[H-1:0];
                    w_y    = r_b[W-1:H] ^ r_b[H-1:0];
                end else begin
                    w_step = 1'b1;
                end
            end
            MUL_MID: begin
                if (w_last) begin
                    w_next = COMBINE;
                end else begin
                    w_step = 1'b1;
                end
            end
            COMBINE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Pmid is still sitting in the multiplier during COMBINE.
    assign w_mid  = w_p ^ r_phi ^ r_plo;
    assign w_comb = {r_phi, r_plo} ^ {{H{1'b0}}, w_mid, {H{1'b0}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_phi   <= '0;
            r_plo   <= '0;
            r_c     <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= c_CNT_FIRST;
                    end
                end
                MUL_HI: begin
                    if (w_last) begin
                        r_phi <= w_p;
                        r_cnt <= c_CNT_FIRST;
                    end else begin
                        r_cnt <= r_cnt << 1;
                    end
                end
                MUL_LO: begin
                    if (w_last) begin
                        r_plo <= w_p;
                        r_cnt <= c_CNT_FIRST;
                    end else begin
                        r_cnt <= r_cnt << 1;
                    end
                end
                MUL_MID: begin
                    if (w_last) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt << 1;
                    end
                end
                COMBINE: begin
                    r_c    <= w_comb;
                    r_done <= 1'b1;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign c    = r_c;

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_gf2_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_karatsuba_gf2_scheduler                                   |
// | Description : Directed self-checking bench for karatsuba_gf2_scheduler at  |
// |               the default width W=224.                                     |
// | Ports       : none                                                         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_karatsuba_gf2_scheduler;

    localparam int W       = 224;
    localparam int LATENCY = 337;
    localparam int BOUND   = 400;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] c;

    int total;
    int bad;

    karatsuba_gf2_scheduler #(
        .W (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Schoolbook carry-less product, independent of the Karatsuba split.
    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] acc;
        logic [2*W-1:0] xs;
        acc = '0;
        xs  = {{W{1'b0}}, x};
        for (int i = 0; i < W; i++) begin
            if (y[i]) acc = acc ^ xs;
            xs = xs << 1;
        end
        return acc;
    endfunction

    // Drives a start pulse from the current time; the next rising edge is edge 0.
    task automatic do_start(input logic [W-1:0] x, input logic [W-1:0] y);
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after edge 0 until done is seen (0 on timeout). Records
    // whether c moved before done. With poke set, a start pulse carrying
    // other operands is driven mid-operation.
    task automatic wait_done(input bit poke, output int n, output bit c_chg);
        logic [2*W-1:0] c0;
        bit             seen;
        c0    = c;
        n     = 0;
        c_chg = 1'b0;
        seen  = 1'b0;
        for (int k = 1; k <= BOUND && !seen; k++) begin
            @(posedge clk);
            #1;
            if (poke && k == 51) start = 1'b0;
            if (done) begin
                n    = k;
                seen = 1'b1;
            end else begin
                if (c !== c0) c_chg = 1'b1;
                if (poke && k == 50) begin
                    a     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                    b     = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
                    start = 1'b1;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        total++;
        if (c !== '0) begin bad++; $display("FAIL reset_c: got %h expected 0", c); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int n;
        bit chg;
        do_start(224'd1, 224'd1);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_after_start: got %b expected 1", busy); end
        wait_done(1'b0, n, chg);
        total++;
        if (n !== LATENCY) begin bad++; $display("FAIL basic_latency: got %0d expected %0d", n, LATENCY); end
        total++;
        if (c !== 448'd1) begin bad++; $display("FAIL basic_c: got %h expected 1", c); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_in_done: got %b expected 0", busy); end
        @(posedge clk);
        #1;
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse_width: got %b expected 0", done); end
        total++;
        if (c !== 448'd1) begin bad++; $display("FAIL basic_c_held: got %h expected 1", c); end
    endtask

    task automatic test_carryless();
        int n;
        bit chg;
        do_start(224'd3, 224'd3);
        wait_done(1'b0, n, chg);
        total++;
        if (c !== 448'd5) begin bad++; $display("FAIL carryless_3x3: got %h expected 5", c); end
    endtask

    task automatic test_boundary();
        int n;
        bit chg;
        logic [W-1:0]   x;
        logic [2*W-1:0] e;
        x      = '0;
        x[223] = 1'b1;
        e      = '0;
        e[446] = 1'b1;
        do_start(x, x);
        wait_done(1'b0, n, chg);
        total++;
        if (c !== e) begin bad++; $display("FAIL boundary_top_bits: got %h expected %h", c, e); end
        x      = '0;
        x[111] = 1'b1;
        x[112] = 1'b1;
        e      = '0;
        e[111] = 1'b1;
        e[112] = 1'b1;
        do_start(x, 224'd1);
        wait_done(1'b0, n, chg);
        total++;
        if (c !== e) begin bad++; $display("FAIL boundary_split: got %h expected %h", c, e); end
    endtask

    task automatic test_random();
        int n;
        bit chg;
        logic [W-1:0]   x;
        logic [W-1:0]   y;
        logic [2*W-1:0] e;
        for (int t = 0; t < 3; t++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            y = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            e = ref_mul(x, y);
            do_start(x, y);
            wait_done(1'b1, n, chg);
            total++;
            if (n !== LATENCY) begin bad++; $display("FAIL random_latency[%0d]: got %0d expected %0d", t, n, LATENCY); end
            total++;
            if (chg !== 1'b0) begin bad++; $display("FAIL random_c_stable[%0d]: got changed=%b expected 0", t, chg); end
            total++;
            if (c !== e) begin bad++; $display("FAIL random_c[%0d]: got %h expected %h", t, c, e); end
        end
    endtask

    task automatic test_reset_abort();
        int  n;
        bit  chg;
        bit  spurious;
        do_start(224'd7, 224'd9);
        repeat (99) @(posedge clk);
        #1;
        rst   = 1'b1;
        start = 1'b1;
        a     = 224'd5;
        b     = 224'd5;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        total++;
        if (c !== '0) begin bad++; $display("FAIL abort_c: got %h expected 0", c); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b expected 0", busy); end
        spurious = 1'b0;
        for (int k = 0; k < 340; k++) begin
            if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
            @(posedge clk);
            #1;
        end
        total++;
        if (spurious !== 1'b0) begin bad++; $display("FAIL abort_no_done: got activity=%b expected 0", spurious); end
        do_start(224'hF, 224'hF);
        wait_done(1'b0, n, chg);
        total++;
        if (n !== LATENCY) begin bad++; $display("FAIL abort_restart_latency: got %0d expected %0d", n, LATENCY); end
        total++;
        if (c !== 448'h55) begin bad++; $display("FAIL abort_restart_c: got %h expected 55", c); end
    endtask

    task automatic test_back_to_back();
        int n;
        bit chg;
        do_start(224'h6, 224'h3);
        wait_done(1'b0, n, chg);
        total++;
        if (c !== 448'hA) begin bad++; $display("FAIL b2b_first_c: got %h expected a", c); end
        do_start(224'h5, 224'h7);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accepted: got busy=%b expected 1", busy); end
        wait_done(1'b0, n, chg);
        total++;
        if (n !== LATENCY) begin bad++; $display("FAIL b2b_latency: got %0d expected %0d", n, LATENCY); end
        total++;
        if (chg !== 1'b0) begin bad++; $display("FAIL b2b_first_held: got changed=%b expected 0", chg); end
        total++;
        if (c !== 448'h1B) begin bad++; $display("FAIL b2b_second_c: got %h expected 1b", c); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic();
        test_carryless();
        test_boundary();
        test_random();
        test_reset_abort();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
